// File: rtl/jtdsp16_pkg.sv
// rtl/jtdsp16_pkg.sv - shared types for the DSP16 external ROM bus arbiter
// Purpose: arbiter state encoding, requester ids and bus widths.
// Ports: none (package).
package jtdsp16_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ID_PT   = 2'd0,
    ID_IF   = 2'd1,
    ID_HOST = 2'd2,
    ID_NONE = 2'd3
  } req_id_t;

endpackage

// File: rtl/jtdsp16_extbus_fbuf.sv
// rtl/jtdsp16_extbus_fbuf.sv - one-entry instruction fetch buffer
// Purpose: remembers the last fetched word so a refetch of the same address
//   is served without a bus access.
// Ports:
//   clk, rst_n, cen      clock, async active-low reset, clock enable
//   look_addr  -> hit    lookup address and hit flag (combinational)
//   hit_data             buffered word
//   wr, wr_addr, wr_data fill the entry (completed fetch)
//   inv, inv_addr        drop the entry when inv_addr matches (host access)
module jtdsp16_extbus_fbuf
  import jtdsp16_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  input  logic [ADDR_W-1:0] look_addr,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data,
  input  logic              wr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              inv,
  input  logic [ADDR_W-1:0] inv_addr
);

  logic              buf_valid;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else if (cen) begin
      if (wr) begin
        buf_valid <= 1'b1;
        buf_addr  <= wr_addr;
        buf_data  <= wr_data;
      end else if (inv && inv_addr == buf_addr) begin
        buf_valid <= 1'b0;
      end
    end
  end

  assign hit      = buf_valid && (look_addr == buf_addr);
  assign hit_data = buf_data;

endmodule

// File: rtl/jtdsp16_extbus_arb.sv
// rtl/jtdsp16_extbus_arb.sv - external ROM bus arbiter for PT / fetch / host
// Purpose: grants the external bus to one of three requesters (pt > if > host,
//   host forced after HOSTMAX denials), runs the cs/ok handshake with a
//   minimum wait and a timeout, and serves refetches from a one-entry buffer.
// Ports:
//   clk, rst_n, cen                 clock, async active-low reset, clock enable
//   pt_req/pt_addr/pt_ack           PT data read requester
//   if_req/if_addr/if_ack           instruction fetch requester
//   host_req/host_addr/host_ack     host/debug peek requester
//   rd_data                         read data, valid with any ack
//   cpu_stall                       halt toward the control unit
//   mem_addr/mem_cs/mem_ok/mem_din  slow memory interface
//   fault                           sticky timeout flag
module jtdsp16_extbus_arb
  import jtdsp16_pkg::*;
#(
  parameter int WAIT    = 1,
  parameter int TIMEOUT = 63,
  parameter int HOSTMAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        pt_req,
  input  logic [15:0] pt_addr,
  output logic        pt_ack,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  input  logic        host_req,
  input  logic [15:0] host_addr,
  output logic        host_ack,
  output logic [15:0] rd_data,
  output logic        cpu_stall,
  output logic [15:0] mem_addr,
  output logic        mem_cs,
  input  logic        mem_ok,
  input  logic [15:0] mem_din,
  output logic        fault
);

  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam logic [3:0]     WAIT_C    = 4'(WAIT);
  localparam logic [TCW-1:0] TIMEOUT_C = TCW'(TIMEOUT);
  localparam logic [2:0]     HOSTMAX_C = 3'(HOSTMAX);

  state_t         state, state_nx;
  req_id_t        id, id_nx, win;
  logic [15:0]    win_addr, addr_nx, rd_nx;
  logic           cs_nx, pt_ack_nx, if_ack_nx, host_ack_nx, fault_nx;
  logic [3:0]     wcnt, wcnt_nx;
  logic [TCW-1:0] tcnt, tcnt_nx, tcnt_inc;
  logic [2:0]     host_deny, deny_nx;
  logic           done_ok, done_to;
  logic           fb_hit;
  logic [15:0]    fb_data;

  // A requester whose ack is showing this cycle has been served; its req may
  // still be high until it reacts, so it must not be granted a second time.
  logic pt_v, if_v, host_v;
  assign pt_v   = pt_req   & ~pt_ack;
  assign if_v   = if_req   & ~if_ack;
  assign host_v = host_req & ~host_ack;

  assign cpu_stall = (pt_req | if_req) & ~(pt_ack | if_ack);

  // mem_ok has priority over a timeout landing on the same cen.
  assign tcnt_inc = tcnt + 1'b1;
  assign done_ok  = (state == ST_BUSY) && (wcnt >= WAIT_C) && mem_ok;
  assign done_to  = (state == ST_BUSY) && !done_ok && (tcnt_inc == TIMEOUT_C);
  assign fault_nx = fault | done_to;

  always_comb begin
    win      = ID_NONE;
    win_addr = pt_addr;
    if (host_v && host_deny == HOSTMAX_C) begin
      win      = ID_HOST;
      win_addr = host_addr;
    end else if (pt_v) begin
      win      = ID_PT;
      win_addr = pt_addr;
    end else if (if_v) begin
      win      = ID_IF;
      win_addr = if_addr;
    end else if (host_v) begin
      win      = ID_HOST;
      win_addr = host_addr;
    end
  end

  jtdsp16_extbus_fbuf u_fbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (cen),
    .look_addr (if_addr),
    .hit       (fb_hit),
    .hit_data  (fb_data),
    .wr        (done_ok && id == ID_IF),
    .wr_addr   (mem_addr),
    .wr_data   (mem_din),
    .inv       ((done_ok || done_to) && id == ID_HOST),
    .inv_addr  (mem_addr)
  );

  always_comb begin
    state_nx    = state;
    id_nx       = id;
    addr_nx     = mem_addr;
    cs_nx       = mem_cs;
    rd_nx       = rd_data;
    pt_ack_nx   = 1'b0;
    if_ack_nx   = 1'b0;
    host_ack_nx = 1'b0;
    wcnt_nx     = wcnt;
    tcnt_nx     = tcnt;
    deny_nx     = host_deny;
    case (state)
      ST_IDLE: begin
        if (win != ID_NONE) begin
          if (win == ID_HOST)
            deny_nx = 3'd0;
          else if (host_req && host_deny != HOSTMAX_C)
            deny_nx = host_deny + 3'd1;
          if (win == ID_IF && fb_hit) begin
            if_ack_nx = 1'b1;
            rd_nx     = fb_data;
          end else begin
            id_nx    = win;
            addr_nx  = win_addr;
            cs_nx    = 1'b1;
            wcnt_nx  = 4'd0;
            tcnt_nx  = '0;
            state_nx = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        wcnt_nx = (wcnt == 4'hF) ? wcnt : wcnt + 4'd1;
        tcnt_nx = tcnt_inc;
        if (done_ok || done_to) begin
          rd_nx    = done_ok ? mem_din : 16'hFFFF;
          cs_nx    = 1'b0;
          state_nx = ST_DONE;
          case (id)
            ID_PT:   pt_ack_nx   = 1'b1;
            ID_IF:   if_ack_nx   = 1'b1;
            ID_HOST: host_ack_nx = 1'b1;
            default: ;
          endcase
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      id        <= ID_NONE;
      mem_addr  <= 16'h0000;
      mem_cs    <= 1'b0;
      rd_data   <= 16'h0000;
      pt_ack    <= 1'b0;
      if_ack    <= 1'b0;
      host_ack  <= 1'b0;
      wcnt      <= 4'd0;
      tcnt      <= '0;
      host_deny <= 3'd0;
      fault     <= 1'b0;
    end else if (cen) begin
      state     <= state_nx;
      id        <= id_nx;
      mem_addr  <= addr_nx;
      mem_cs    <= cs_nx;
      rd_data   <= rd_nx;
      pt_ack    <= pt_ack_nx;
      if_ack    <= if_ack_nx;
      host_ack  <= host_ack_nx;
      wcnt      <= wcnt_nx;
      tcnt      <= tcnt_nx;
      host_deny <= deny_nx;
      fault     <= fault_nx;
    end
  end

endmodule

// File: tb/tb_jtdsp16_extbus_arb.sv
// tb/tb_jtdsp16_extbus_arb.sv - scoreboard bench for jtdsp16_extbus_arb
module tb_jtdsp16_extbus_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b1;
  logic        pt_req = 1'b0, if_req = 1'b0, host_req = 1'b0;
  logic [15:0] pt_addr = '0, if_addr = '0, host_addr = '0;
  logic        pt_ack, if_ack, host_ack;
  logic [15:0] rd_data, mem_addr;
  logic        cpu_stall, mem_cs, fault;
  logic        mem_ok = 1'b0;
  logic [15:0] mem_din = '0;

  always #5 clk = ~clk;

  jtdsp16_extbus_arb dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .pt_req(pt_req), .pt_addr(pt_addr), .pt_ack(pt_ack),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .host_req(host_req), .host_addr(host_addr), .host_ack(host_ack),
    .rd_data(rd_data), .cpu_stall(cpu_stall),
    .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_ok(mem_ok), .mem_din(mem_din),
    .fault(fault)
  );

  typedef struct {
    logic [15:0] data;
    int          cs;
  } exp_t;

  exp_t q_pt[$], q_if[$], q_host[$];
  int total = 0, bad = 0;
  int cs_cnt = 0, n_if_acks = 0;
  int ok_delay = 3;
  bit mem_dead = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input int id, input logic [15:0] d, input int cs);
    exp_t e;
    e.data = d;
    e.cs   = cs;
    case (id)
      0:       q_pt.push_back(e);
      1:       q_if.push_back(e);
      default: q_host.push_back(e);
    endcase
  endtask

  task automatic pop_chk(input int id);
    exp_t e;
    bit   have = 1'b0;
    case (id)
      0:       if (q_pt.size() > 0)   begin e = q_pt.pop_front();   have = 1'b1; end
      1:       if (q_if.size() > 0)   begin e = q_if.pop_front();   have = 1'b1; end
      default: if (q_host.size() > 0) begin e = q_host.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      total++;
      bad++;
      $display("FAIL unexpected_ack_id%0d: got=ack want=none", id);
    end else begin
      chk($sformatf("ack_data_id%0d", id), rd_data, e.data);
      chk($sformatf("ack_cs_cycles_id%0d", id), cs_cnt, e.cs);
    end
  endtask

  // Monitor: pops the scoreboard on every ack, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      cs_cnt = 0;
    end else begin
      if (mem_cs) cs_cnt++;
      if (int'(pt_ack) + int'(if_ack) + int'(host_ack) > 1) begin
        total++;
        bad++;
        $display("FAIL multi_ack: got=%b%b%b want=one-hot", pt_ack, if_ack, host_ack);
      end
      if (pt_ack) pop_chk(0);
      if (if_ack) begin pop_chk(1); n_if_acks++; end
      if (host_ack) pop_chk(2);
      if (pt_ack || if_ack || host_ack) cs_cnt = 0;
    end
  end

  // Slow memory: returns addr^A5A5 once cs has been high ok_delay cycles.
  initial begin
    int age;
    age = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_cs && rst_n) begin
        age++;
        if (!mem_dead && age >= ok_delay) begin
          mem_ok  = 1'b1;
          mem_din = mem_addr ^ 16'hA5A5;
        end
      end else begin
        age    = 0;
        mem_ok = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int id, output int lat);
    bit seen = 1'b0;
    lat = 0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(posedge clk);
      #1;
      lat++;
      seen = (id == 0) ? pt_ack : (id == 1) ? if_ack : host_ack;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL ack_wait_id%0d: got=none want=ack", id);
    end
  endtask

  task automatic access(input int id, input logic [15:0] a, input logic [15:0] d,
                        input int cs, output int lat);
    push(id, d, cs);
    case (id)
      0:       begin pt_addr = a;   pt_req = 1'b1;   end
      1:       begin if_addr = a;   if_req = 1'b1;   end
      default: begin host_addr = a; host_req = 1'b1; end
    endcase
    wait_ack(id, lat);
    case (id)
      0:       pt_req = 1'b0;
      1:       if_req = 1'b0;
      default: host_req = 1'b0;
    endcase
  endtask

  initial begin
    int lat, lat_a, lat_b, cnt, base;
    bit if_done;
    logic [15:0] t4a[5];
    logic [15:0] t4d[5];
    t4a = '{16'h0300, 16'h0301, 16'h0302, 16'h0303, 16'h0304};
    t4d = '{16'hA6A5, 16'hA6A4, 16'hA6A7, 16'hA6A6, 16'hA6A1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_cs", mem_cs, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_acks", {pt_ack, if_ack, host_ack}, 0);
    chk("rst_fault", fault, 0);
    chk("rst_cpu_stall", cpu_stall, 0);
    rst_n = 1'b1;
    idle();

    // Fetch miss, then immediate refetch hit, then hit with cen held low.
    access(1, 16'h0100, 16'hA4A5, 3, lat);
    chk("t1_latency", lat, 4);
    idle();
    access(1, 16'h0100, 16'hA4A5, 0, lat);
    chk("t3_hit_latency", lat, 1);
    idle();
    push(1, 16'hA4A5, 0);
    cen = 1'b0;
    if_addr = 16'h0100;
    if_req = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      cnt += int'(if_ack);
    end
    chk("cen_low_no_ack", cnt, 0);
    cen = 1'b1;
    wait_ack(1, lat);
    if_req = 1'b0;
    chk("cen_resume_latency", lat, 1);

    // Host access to the buffered address invalidates; to another does not.
    idle();
    access(2, 16'h0100, 16'hA4A5, 3, lat);
    idle();
    access(1, 16'h0100, 16'hA4A5, 3, lat);
    chk("inval_refetch_latency", lat, 4);
    idle();
    access(2, 16'h0555, 16'hA0F0, 3, lat);
    idle();
    access(1, 16'h0100, 16'hA4A5, 0, lat);
    chk("other_host_keeps_buf", lat, 1);

    // mem_ok during the first cs cycle (wcnt<WAIT) must be ignored.
    ok_delay = 1;
    idle();
    access(0, 16'h1234, 16'hB791, 2, lat);
    chk("early_ok_latency", lat, 3);
    ok_delay = 3;

    // Simultaneous pt+if: pt first, stall held until if_ack.
    idle();
    push(0, 16'h85A5, 3);
    push(1, 16'hA7A5, 3);
    pt_addr = 16'h2000;
    if_addr = 16'h0200;
    pt_req = 1'b1;
    if_req = 1'b1;
    idle();
    chk("t2_first_addr", mem_addr, 16'h2000);
    chk("t2_first_cs", mem_cs, 1);
    cnt = 0;
    if_done = 1'b0;
    for (int c = 0; c < 40 && !if_done; c++) begin
      if (!pt_ack && !if_ack && !cpu_stall) cnt++;
      if (pt_ack) pt_req = 1'b0;
      if (if_ack) begin
        if_req = 1'b0;
        if_done = 1'b1;
      end else begin
        idle();
      end
    end
    chk("t2_if_done", if_done, 1);
    chk("t2_stall_gaps", cnt, 0);
    chk("t2_stall_released", cpu_stall, 0);

    // Host starvation guard: host wins the 5th arbitration.
    idle();
    base = n_if_acks;
    push(2, 16'hACA5, 3);
    host_addr = 16'h0900;
    host_req = 1'b1;
    fork
      begin
        wait_ack(2, lat_a);
        host_req = 1'b0;
        chk("t4_if_grants_before_host", n_if_acks - base, 4);
      end
      begin
        for (int i = 0; i < 5; i++) access(1, t4a[i], t4d[i], 3, lat_b);
      end
    join

    // Timeout: FFFF, sticky fault, fetch buffer not written.
    idle();
    mem_dead = 1'b1;
    access(0, 16'h4000, 16'hFFFF, 63, lat);
    chk("t5_fault", fault, 1);
    idle();
    access(1, 16'h0700, 16'hFFFF, 63, lat);
    mem_dead = 1'b0;
    idle();
    access(1, 16'h0700, 16'hA2A5, 3, lat);
    chk("t5_no_buf_on_timeout", lat, 4);
    chk("t5_fault_sticky", fault, 1);

    // Reset in the middle of a bus access.
    idle();
    pt_addr = 16'h0800;
    pt_req = 1'b1;
    cnt = 0;
    while (!mem_cs && cnt < 20) begin
      idle();
      cnt++;
    end
    chk("t6_cs_seen", mem_cs, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_cs_async_drop", mem_cs, 0);
    chk("t6_no_ack", {pt_ack, if_ack, host_ack}, 0);
    idle();
    chk("t6_fault_cleared", fault, 0);
    chk("t6_rd_data_reset", rd_data, 0);
    push(0, 16'hADA5, 3);
    rst_n = 1'b1;
    wait_ack(0, lat);
    pt_req = 1'b0;
    chk("t6_reissue_latency", lat, 4);
    idle();
    access(1, 16'h0700, 16'hA2A5, 3, lat);
    chk("t6_buf_cleared", lat, 4);

    repeat (3) idle();
    chk("sb_pt_left", q_pt.size(), 0);
    chk("sb_if_left", q_if.size(), 0);
    chk("sb_host_left", q_host.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
